// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, the fetch/data requesters and the shared
// memory port. The master modport is the arbiter's view of it.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic              i_valid;
    logic [XLEN-1:0]   i_addr;
    logic              i_ready;
    logic              i_rvalid;
    logic              d_valid;
    logic              d_we;
    logic [XLEN/8-1:0] d_be;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        input  i_valid, i_addr,
        input  d_valid, d_we, d_be, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output i_ready, i_rvalid,
        output d_ready, d_rvalid,
        output rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output i_valid, i_addr,
        output d_valid, d_we, d_be, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  i_ready, i_rvalid,
        input  d_ready, d_rvalid,
        input  rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the unified memory port: data first, bounded
// fetch starvation, one outstanding transaction, bus timeout as error.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);

    localparam int BW = XLEN / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic            owner_d;
    logic            lat_we;
    logic [BW-1:0]   lat_be;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [SW-1:0]   starve_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;
    logic            i_rvalid_q;
    logic            d_rvalid_q;

    logic starved;
    logic i_win;
    logic d_win;
    logic timeout_hit;

    assign starved = (starve_cnt == SW'(STARVE_LIMIT));
    assign i_win   = (state == IDLE) && bus.i_valid &&
                     (!bus.d_valid || starved);
    assign d_win   = (state == IDLE) && bus.d_valid &&
                     !(bus.i_valid && starved);

    // The wait count about to reach the limit in this BUSY cycle
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

    assign bus.i_ready   = i_win;
    assign bus.d_ready   = d_win;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = lat_we;
    assign bus.mem_be    = lat_be;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            lat_we      <= 1'b0;
            lat_be      <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_win || d_win) begin
                        owner_d   <= d_win;
                        lat_we    <= d_win && bus.d_we;
                        lat_be    <= d_win ? bus.d_be : '1;
                        lat_addr  <= d_win ? bus.d_addr : bus.i_addr;
                        lat_wdata <= d_win ? bus.d_wdata : '0;
                        wait_cnt  <= '0;
                        state     <= BUSY;
                        if (i_win || !bus.i_valid)
                            starve_cnt <= '0;
                        else if (!starved)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        rsp_rdata_q <= lat_we ? '0 : bus.mem_rdata;
                        rsp_err_q   <= 1'b0;
                        i_rvalid_q  <= !owner_d;
                        d_rvalid_q  <= owner_d;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        i_rvalid_q  <= !owner_d;
                        d_rvalid_q  <= owner_d;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
